// File: rtl/uart_rx_loader.sv
// uart_rx_loader: deserialises 8N1 frames from rxd into a registered wdata/wr load pair for the downstream counter
module uart_rx_loader #(
  parameter int BIT_CLKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] wdata,
  output logic       wr,
  output logic       frame_err,
  output logic       busy
);
  localparam int W = $clog2(BIT_CLKS);
  localparam logic [W-1:0] HALF_END = W'(BIT_CLKS / 2 - 1);
  localparam logic [W-1:0] BIT_END = W'(BIT_CLKS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic s1, rx_s, bit_end, shift, good, bad;
  logic [W-1:0] cnt;
  logic [2:0] bitn;
  logic [7:0] shreg;
  assign bit_end = cnt == BIT_END;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    shift = 1'b0;
    good = 1'b0;
    bad = 1'b0;
    unique case (state)
      IDLE:  state_n = rx_s ? IDLE : START;
      START: state_n = cnt == HALF_END ? (rx_s ? IDLE : DATA) : START;
      DATA: begin
        shift = bit_end;
        state_n = bit_end && bitn == 3'd7 ? STOP : DATA;
      end
      STOP: begin
        good = bit_end && rx_s;
        bad = bit_end && !rx_s;
        state_n = good ? IDLE : bad ? BRK : STOP;
      end
      BRK:   state_n = rx_s ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bitn <= '0;
      shreg <= '0;
      wdata <= '0;
      wr <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1 <= rxd;
      rx_s <= s1;
      state <= state_n;
      cnt <= (state_n != state || bit_end) ? '0 : cnt + 1'b1;
      if (state == START) bitn <= '0;
      if (shift) begin
        shreg <= {rx_s, shreg[7:1]};
        bitn <= bitn + 1'b1;
      end
      wr <= good;
      frame_err <= bad;
      if (good) wdata <= shreg;
    end
  end
endmodule

// File: tb/tb_uart_rx_loader.sv
// tb_uart_rx_loader: directed frames with a scoreboard of expected wr/frame_err events checked by a monitor
module tb_uart_rx_loader;
  logic clk = 1'b0;
  logic reset, rxd, wr, frame_err, busy;
  logic [7:0] wdata, q, cq;
  int cyc = 0, n_cmp = 0, n_bad = 0, stage = 0;
  logic prev_busy = 1'b0;
  typedef struct {logic ferr; logic [7:0] data; int cyc;} exp_t;
  exp_t sb[$];

  uart_rx_loader #(.BIT_CLKS(8)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .wdata(wdata), .wr(wr), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) q <= reset ? 8'h00 : wr ? wdata : q + 8'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic [7:0] prev, input logic expect_evt);
    exp_t e;
    e.ferr = !stop;
    e.data = stop ? b : prev;
    e.cyc = cyc + 1 + 78;
    if (expect_evt) sb.push_back(e);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (8) @(negedge clk);
    end
    rxd = stop;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stage == 1) begin
        chk("cnt_load", q, cq);
        stage = 2;
      end else if (stage == 2) begin
        chk("cnt_incr", q, cq + 8'd1);
        stage = 0;
      end
      if (wr || frame_err) begin
        chk("pulse_excl", wr && frame_err, 0);
        chk("event_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("kind_ferr", frame_err, e.ferr);
          chk("wdata", wdata, e.data);
          chk("event_cycle", cyc, e.cyc);
          if (wr) begin
            chk("busy_fall", {prev_busy, busy}, 2'b10);
            cq = wdata;
            stage = 1;
          end
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    int nb, c;
    rxd = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_wr", wr, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    send(8'h55, 1'b1, 8'h00, 1'b1);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    nb = 0;
    repeat (12) begin
      @(negedge clk);
      nb += int'(busy);
    end
    chk("glitch_busy_cycles", nb, 4);
    chk("glitch_wdata", wdata, 8'h55);
    send(8'hA3, 1'b1, 8'h55, 1'b1);
    send(8'h81, 1'b0, 8'hA3, 1'b1);
    repeat (20) @(negedge clk);
    chk("break_busy_low", busy, 1);
    rxd = 1'b1;
    c = cyc;
    repeat (2) @(negedge clk);
    chk("break_busy_hold", busy, 1);
    @(negedge clk);
    chk("break_busy_exit", busy, 0);
    chk("break_exit_cycle", cyc - c, 3);
    chk("ferr_wdata_kept", wdata, 8'hA3);
    repeat (5) @(negedge clk);
    send(8'hA3, 1'b1, 8'hA3, 1'b1);
    send(8'h0F, 1'b1, 8'hA3, 1'b1);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    fork
      send(8'hF0, 1'b1, 8'h0F, 1'b0);
      begin
        repeat (44) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_wdata", wdata, 8'h00);
        chk("midrst_wr", wr, 0);
        chk("midrst_ferr", frame_err, 0);
        chk("midrst_busy", busy, 0);
      end
    join
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h3C, 1'b1, 8'h00, 1'b1);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("final_wdata", wdata, 8'h3C);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
